reg_demux_file: RTL and testbench
=================================

# reg_demux_file

Write-side counterpart to the datapath's read-select muxes. The block takes one shared bus value and steers it, through a one-hot destination decode, into one of NREG general-purpose registers. It then presents two independently selected registers on SR1_OUT/SR2_OUT for the SR1/SR2 operand paths. Writes pass through a one-entry staging register with forwarding, so the decode-and-commit path is registered while reads keep normal register semantics.

## Interface
- width, 16, data width of bus and registers
- NREG, 8, number of registers (power of two)
- SELW, 3, select width, log2(NREG)

- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- In  in  width  bus data to be written
- DR  in  SELW  destination register select
- LD_REG  in  1  write request, sampled at rising edge
- SR1  in  SELW  read port 1 select
- SR2  in  SELW  read port 2 select
- SR1_OUT  out  width  register SR1 contents, combinational
- SR2_OUT  out  width  register SR2 contents, combinational
- LD_ONEHOT  out  NREG  one-hot decode of the register committed this cycle; all zeros if none
- STAGE_VALID  out  1  staging register holds an uncommitted write

## Operation
- State:
  - array R[0..NREG-1]
  - staging register: stg_data, stg_dr, stg_v
- Edge with LD_REG=1: stg_data<=In, stg_dr<=DR, stg_v<=1.
- Edge with LD_REG=0: stg_v<=0.
- Commit: on every edge where stg_v=1 (before the edge), R[stg_dr]<=stg_data.
- Commit and capture happen on the same edge. A write captured at edge N commits at edge N+1.
- LD_ONEHOT = stg_v ? (1<<stg_dr) : 0. This is a combinational decode of registered state and is glitch-free relative to Clk.
- Read ports:
  - SRx_OUT = (stg_v && stg_dr==SRx) ? stg_data : R[SRx].
  - The staging register is the newest value and always wins over the array.
- Back-to-back writes to the same DR:
  - Edge N+1 commits the older value to the array and captures the newer value in staging.
  - Reads return the newer value from N+1 on.
  - After commit at N+2, the array holds the newer value.
- Writes to different DRs on consecutive cycles behave independently. No write is ever dropped.
- SR1==SR2 is legal: both outputs are identical.
- There are no illegal select values, because NREG=2^SELW.
- Externally visible semantics equal a plain register file: the value written with LD_REG at edge N is readable from just after edge N.

## Timing
- Reset_n=0, asynchronous, immediate:
  - all R[i]=0, stg_v=0, stg_data=0, stg_dr=0
  - SR1_OUT=SR2_OUT=0, LD_ONEHOT=0, STAGE_VALID=0
- Reset assertion discards any in-flight write. Reset has priority over LD_REG.
- Reset deassertion: the first edge with Reset_n=1 samples LD_REG normally.
- Write-to-read visibility: 0 cycles after the capturing edge, through forwarding.
- Write-to-array: 1 cycle after the capturing edge.
- Throughput: one write per cycle, sustained indefinitely.
- SRx to SRx_OUT: purely combinational, with no cycle of latency.

## Test plan
- Reset:
  - Write 0xBEEF to R3, then pulse Reset_n low mid-cycle.
  - Required: SR1_OUT (SR1=3) reads 0x0000 immediately, STAGE_VALID=0, and the array does not commit 0xBEEF after release.
- Single write:
  - Set LD_REG=1, DR=5, In=0x1234 for one cycle.
  - Just after the edge: SR2=5 reads 0x1234 and STAGE_VALID=1.
  - Next edge: LD_ONEHOT was 0x20 in the prior cycle, STAGE_VALID=0, and SR2_OUT is still 0x1234 (from the array).
- Back-to-back writes to the same register:
  - Write DR=2 with 0xAAAA, then DR=2 with 0x5555 on consecutive edges.
  - SR1=2 reads 0xAAAA then 0x5555, never 0xAAAA after the second edge.
  - Final array value is 0x5555.
- Interleaved writes:
  - Write R0=0x0001, R7=0xFFFF, R0=0x0002 on consecutive edges, with SR1=0 and SR2=7.
  - SR1_OUT sequence: 0x0001, 0x0001, 0x0002.
  - SR2_OUT sequence: 0x0000, 0xFFFF, 0xFFFF.
  - LD_ONEHOT sequence: 0x01, 0x80, 0x01.
- Full sweep:
  - Write R[i]=0x1000+i for i=0..7 on consecutive cycles.
  - Then read all (SR1=i, SR2=7-i). Every value must match.
  - LD_ONEHOT must never have more than one bit set.
- Idle cycles:
  - With LD_REG=0 for 10 cycles after writes, register contents are unchanged, LD_ONEHOT=0 and STAGE_VALID=0.

Source files
------------

// File: rtl/reg_demux_file.sv
// Register file with a one-entry staging register: captures a write at edge N, commits it to the array at N+1.
// Reads forward from staging, so a write is visible 0 cycles after capture; no backpressure, one write per cycle.
module reg_demux_file #(
    parameter int width = 16,
    parameter int NREG  = 8,
    parameter int SELW  = 3
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [width-1:0]  In,
    input  logic [SELW-1:0]   DR,
    input  logic              LD_REG,
    input  logic [SELW-1:0]   SR1,
    input  logic [SELW-1:0]   SR2,
    output logic [width-1:0]  SR1_OUT,
    output logic [width-1:0]  SR2_OUT,
    output logic [NREG-1:0]   LD_ONEHOT,
    output logic              STAGE_VALID
);

    logic [width-1:0] r_q [NREG];
    logic [width-1:0] r_d [NREG];
    logic [width-1:0] stg_data_q, stg_data_d;
    logic [SELW-1:0]  stg_dr_q, stg_dr_d;
    logic             stg_v_q, stg_v_d;

    always_comb begin
        LD_ONEHOT = '0;
        if (stg_v_q) begin
            LD_ONEHOT = NREG'(1) << stg_dr_q;
        end
    end

    // Commit the staged write through the one-hot decode while capturing the next one.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            r_d[i] = r_q[i];
            if (LD_ONEHOT[i]) begin
                r_d[i] = stg_data_q;
            end
        end
        stg_v_d    = LD_REG;
        stg_data_d = stg_data_q;
        stg_dr_d   = stg_dr_q;
        if (LD_REG) begin
            stg_data_d = In;
            stg_dr_d   = DR;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_q[i] <= '0;
            end
            stg_data_q <= '0;
            stg_dr_q   <= '0;
            stg_v_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_q[i] <= r_d[i];
            end
            stg_data_q <= stg_data_d;
            stg_dr_q   <= stg_dr_d;
            stg_v_q    <= stg_v_d;
        end
    end

    // Staging holds the newest value for its register, so it wins over the array.
    always_comb begin
        SR1_OUT = r_q[SR1];
        SR2_OUT = r_q[SR2];
        if (stg_v_q && (stg_dr_q == SR1)) begin
            SR1_OUT = stg_data_q;
        end
        if (stg_v_q && (stg_dr_q == SR2)) begin
            SR2_OUT = stg_data_q;
        end
    end

    assign STAGE_VALID = stg_v_q;

endmodule

// File: tb/tb_reg_demux_file.sv
module tb_reg_demux_file;

    logic        Clk;
    logic        Reset_n;
    logic [15:0] In;
    logic [2:0]  DR;
    logic        LD_REG;
    logic [2:0]  SR1;
    logic [2:0]  SR2;
    logic [15:0] SR1_OUT;
    logic [15:0] SR2_OUT;
    logic [7:0]  LD_ONEHOT;
    logic        STAGE_VALID;

    int total;
    int bad;

    reg_demux_file #(.width(16), .NREG(8), .SELW(3)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .In          (In),
        .DR          (DR),
        .LD_REG      (LD_REG),
        .SR1         (SR1),
        .SR2         (SR2),
        .SR1_OUT     (SR1_OUT),
        .SR2_OUT     (SR2_OUT),
        .LD_ONEHOT   (LD_ONEHOT),
        .STAGE_VALID (STAGE_VALID)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; LD_REG = 1'b0; In = '0; DR = '0; SR1 = 3'd3; SR2 = 3'd0;
        #1;
        total++; if (SR1_OUT !== 16'h0000 || SR2_OUT !== 16'h0000) begin bad++; $display("FAIL por_read sr1=%h sr2=%h want 0000", SR1_OUT, SR2_OUT); end
        total++; if (LD_ONEHOT !== 8'h00 || STAGE_VALID !== 1'b0) begin bad++; $display("FAIL por_ctrl onehot=%h sv=%b want 00/0", LD_ONEHOT, STAGE_VALID); end
        @(negedge Clk); @(negedge Clk);
        Reset_n = 1'b1;
        LD_REG = 1'b1; DR = 3'd3; In = 16'hBEEF;
        tick();
        LD_REG = 1'b0;
        total++; if (SR1_OUT !== 16'hBEEF || STAGE_VALID !== 1'b1) begin bad++; $display("FAIL rst_prewrite sr1=%h sv=%b want BEEF/1", SR1_OUT, STAGE_VALID); end
        #2 Reset_n = 1'b0;
        #1;
        total++; if (SR1_OUT !== 16'h0000 || STAGE_VALID !== 1'b0 || LD_ONEHOT !== 8'h00) begin bad++; $display("FAIL rst_async sr1=%h sv=%b oh=%h want 0000/0/00", SR1_OUT, STAGE_VALID, LD_ONEHOT); end
        #2 Reset_n = 1'b1;
        tick();
        total++; if (SR1_OUT !== 16'h0000 || STAGE_VALID !== 1'b0) begin bad++; $display("FAIL rst_no_commit sr1=%h sv=%b want 0000/0", SR1_OUT, STAGE_VALID); end
    endtask

    task automatic test_single_write();
        SR2 = 3'd5;
        LD_REG = 1'b1; DR = 3'd5; In = 16'h1234;
        tick();
        LD_REG = 1'b0;
        total++; if (SR2_OUT !== 16'h1234 || STAGE_VALID !== 1'b1) begin bad++; $display("FAIL single_fwd sr2=%h sv=%b want 1234/1", SR2_OUT, STAGE_VALID); end
        total++; if (LD_ONEHOT !== 8'h20) begin bad++; $display("FAIL single_onehot got=%h want 20", LD_ONEHOT); end
        tick();
        total++; if (SR2_OUT !== 16'h1234 || STAGE_VALID !== 1'b0 || LD_ONEHOT !== 8'h00) begin bad++; $display("FAIL single_array sr2=%h sv=%b oh=%h want 1234/0/00", SR2_OUT, STAGE_VALID, LD_ONEHOT); end
    endtask

    task automatic test_back_to_back();
        SR1 = 3'd2;
        LD_REG = 1'b1; DR = 3'd2; In = 16'hAAAA;
        tick();
        total++; if (SR1_OUT !== 16'hAAAA) begin bad++; $display("FAIL b2b_first got=%h want AAAA", SR1_OUT); end
        In = 16'h5555;
        tick();
        LD_REG = 1'b0;
        total++; if (SR1_OUT !== 16'h5555) begin bad++; $display("FAIL b2b_second got=%h want 5555", SR1_OUT); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (SR1_OUT !== 16'h5555 || STAGE_VALID !== 1'b0) begin bad++; $display("FAIL b2b_array k=%0d got=%h sv=%b want 5555/0", k, SR1_OUT, STAGE_VALID); end
        end
    endtask

    task automatic test_interleaved();
        logic [2:0]  dr_v [3];
        logic [15:0] in_v [3];
        logic [15:0] e1 [3];
        logic [15:0] e2 [3];
        logic [7:0]  eoh [3];
        dr_v = '{3'd0, 3'd7, 3'd0};
        in_v = '{16'h0001, 16'hFFFF, 16'h0002};
        e1   = '{16'h0001, 16'h0001, 16'h0002};
        e2   = '{16'h0000, 16'hFFFF, 16'hFFFF};
        eoh  = '{8'h01, 8'h80, 8'h01};
        // R7 still holds its reset value here, which the SR2 sequence relies on.
        SR1 = 3'd0; SR2 = 3'd7;
        for (int k = 0; k < 3; k++) begin
            LD_REG = 1'b1; DR = dr_v[k]; In = in_v[k];
            tick();
            total++; if (SR1_OUT !== e1[k] || SR2_OUT !== e2[k] || LD_ONEHOT !== eoh[k]) begin
                bad++; $display("FAIL interleave k=%0d sr1=%h sr2=%h oh=%h want %h/%h/%h", k, SR1_OUT, SR2_OUT, LD_ONEHOT, e1[k], e2[k], eoh[k]);
            end
        end
        LD_REG = 1'b0;
        tick();
    endtask

    task automatic test_sweep();
        logic [15:0] exp1, exp2;
        for (int i = 0; i < 8; i++) begin
            LD_REG = 1'b1; DR = 3'(i); In = 16'h1000 + 16'(i);
            tick();
            total++; if ($countones(LD_ONEHOT) > 1 || LD_ONEHOT !== (8'h01 << i)) begin bad++; $display("FAIL sweep_onehot i=%0d got=%h want %h", i, LD_ONEHOT, 8'h01 << i); end
        end
        LD_REG = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            SR1 = 3'(i); SR2 = 3'(7 - i);
            exp1 = 16'h1000 + 16'(i);
            exp2 = 16'h1000 + 16'(7 - i);
            #1;
            total++; if (SR1_OUT !== exp1 || SR2_OUT !== exp2) begin bad++; $display("FAIL sweep_read i=%0d sr1=%h sr2=%h want %h/%h", i, SR1_OUT, SR2_OUT, exp1, exp2); end
        end
    endtask

    task automatic test_idle();
        LD_REG = 1'b0; DR = 3'd4; In = 16'hDEAD;
        SR1 = 3'd3; SR2 = 3'd3;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++; if (LD_ONEHOT !== 8'h00 || STAGE_VALID !== 1'b0) begin bad++; $display("FAIL idle_ctrl k=%0d oh=%h sv=%b want 00/0", k, LD_ONEHOT, STAGE_VALID); end
        end
        total++; if (SR1_OUT !== 16'h1003 || SR2_OUT !== 16'h1003) begin bad++; $display("FAIL idle_same_sel sr1=%h sr2=%h want 1003/1003", SR1_OUT, SR2_OUT); end
        SR2 = 3'd4;
        #1;
        total++; if (SR2_OUT !== 16'h1004) begin bad++; $display("FAIL idle_hold got=%h want 1004", SR2_OUT); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_interleaved();
        test_sweep();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
